mem_master: RTL

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_master_pkg.sv | 17 +
 rtl/mem_wait_cnt.sv | 32 +++
 rtl/mem_master.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_master_pkg.sv
// Shared types and default constants for the mem_master block.
// Optional misaligned-address rejection is enabled by defining MEM_MASTER_ALIGN_CHK_EN.
package mem_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_ACCESS_CYC = 2;
  // Wide enough for the largest legal AccessCycles (15).
  localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter timing the memory read access; done flags the last cycle.
module mem_wait_cnt
  import mem_master_pkg::*;
#(
  parameter int CntWidth = CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [CntWidth-1:0] load_val,
  input  logic                dec,
  output logic                done
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == CntWidth'(1));

endmodule

// File: rtl/mem_master.sv
// CPU-request to simple synchronous memory master (IDLE -> ACCESS -> RESP).
// Define MEM_MASTER_ALIGN_CHK_EN to reject non-word-aligned requests with rsp_err.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int DataWidth    = DEF_DATA_W,
  parameter int AddrWidth    = DEF_ADDR_W,
  parameter int AccessCycles = DEF_ACCESS_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [AddrWidth+1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_req,
  output logic                 mem_rdwr_bar,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  state_e               state_q, state_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_rdwr_bar_q, mem_rdwr_bar_d;
  logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0] mem_wdata_q, mem_wdata_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DataWidth-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 cnt_load, cnt_dec, cnt_done;
  logic                 misalign;

`ifdef MEM_MASTER_ALIGN_CHK_EN
  assign misalign = |req_addr[1:0];
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^req_addr[1:0];
  assign misalign = 1'b0;
`endif

  mem_wait_cnt #(.CntWidth(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (CNT_W'(AccessCycles)),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    mem_req_d      = mem_req_q;
    mem_rdwr_bar_d = mem_rdwr_bar_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_err_d      = rsp_err_q;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          wdata_d     = req_wdata;
          mem_addr_d  = req_addr[AddrWidth+1:2];
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          cnt_load    = 1'b1;
          if (misalign) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // First ACCESS cycle only launches the bus; the counter starts once mem_req is up.
        if (!mem_req_q) begin
          mem_req_d      = 1'b1;
          mem_rdwr_bar_d = !we_q;
          mem_wdata_d    = we_q ? wdata_q : '0;
        end else if (we_q || cnt_done) begin
          mem_req_d      = 1'b0;
          mem_rdwr_bar_d = 1'b1;
          mem_wdata_d    = '0;
          rsp_valid_d    = 1'b1;
          rsp_rdata_d    = we_q ? '0 : mem_rdata;
          state_d        = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      mem_req_q      <= 1'b0;
      mem_rdwr_bar_q <= 1'b1;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      mem_req_q      <= mem_req_d;
      mem_rdwr_bar_q <= mem_rdwr_bar_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_req      = mem_req_q;
  assign mem_rdwr_bar = mem_rdwr_bar_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;

endmodule
